serial_addsub: RTL and testbench
================================

# serial_addsub

Bit-serial two's-complement adder/subtractor built around a single 1-bit full-adder slice with a registered carry. It accepts two WIDTH-bit operands through a start/done handshake and processes one bit per clock, LSB first. Results appear after WIDTH+1 cycles. It is the sequential, area-minimal counterpart to the combinational ripple adders and serves as the arithmetic datapath for multi-cycle ALU operations.

## Interface

- WIDTH, 32, operand and result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when the block is not in RUN
- sub  input  1  0 = a+b, 1 = a−b; sampled with start
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse; result, cout and overflow are valid
- result  output  WIDTH  sum/difference, held until the next accepted start
- cout  output  1  final carry out (for sub: 1 = no borrow, i.e. a ≥ b unsigned)
- overflow  output  1  signed overflow, equal to the carry into the MSB XOR the carry out of the MSB

## Operation

- **States:**
  - IDLE → RUN on start.
  - RUN → RUN while count < WIDTH−1.
  - RUN → DONE after bit WIDTH−1.
  - DONE → RUN on start; otherwise DONE → IDLE.
- **Accept (IDLE or DONE with start=1):**
  - Load opA ← a.
  - Load opB ← sub ? ~b : b.
  - Carry ← sub.
  - count ← 0.
  - Clear result.
- **RUN, each cycle:**
  - Slice inputs are opA[0], opB[0] and carry.
  - Sum s = opA[0]^opB[0]^carry.
  - c_next = majority(opA[0], opB[0], carry).
  - opA and opB shift right by 1.
  - result shifts right with s entering at bit WIDTH−1.
  - carry ← c_next.
  - count ← count+1.
- **MSB cycle (count = WIDTH−1):**
  - Register the carry into the MSB (the current carry) for overflow.
  - cout ← c_next.
  - overflow ← carry ^ c_next.
- **Arithmetic:** modulo 2^WIDTH. Subtraction is A + ~B + 1. There is no saturation.
- **start while busy=1:** ignored. Operands are not re-sampled.
- **Output hold:** result, cout and overflow hold their values from DONE until the next accepted start clears them.
- **Reset (any time, including mid-RUN):**
  - State goes to IDLE.
  - busy, done, result, cout, overflow, count, carry and operand registers all go to 0.
  - No partial result survives reset.

## Timing

- **Start accepted at rising edge E:**
  - busy = 1 from E through edge E+WIDTH.
  - done = 1 for exactly the cycle between E+WIDTH and E+WIDTH+1.
- **Latency:** WIDTH+1 cycles from the accepting edge to the done pulse.
- **Back-to-back issue:** start held high during DONE is accepted at E+WIDTH+1. Throughput is one operation per WIDTH+1 cycles and there are no idle gaps.
- **Output timing:**
  - done and busy are registered and are never high together.
  - result, cout and overflow change only on RUN edges or on reset, and are stable throughout the done cycle.
- **Reset is asynchronous:** outputs go to 0 immediately on rst rising, independent of clk. Release is synchronous to the next clk edge; start is sampled from the first edge after rst falls.

## Test plan

1. **Reset values:** WIDTH=8. Assert rst mid-stream → busy=0, done=0, result=0x00, cout=0, overflow=0 immediately, without a clock edge.
2. **Add with signed overflow:** WIDTH=8, a=0x7F, b=0x01, sub=0. Pulse start → done exactly 9 cycles later; result=0x80, cout=0, overflow=1; busy high for 8 cycles.
3. **Subtract with borrow:**
   - WIDTH=8, a=0x05, b=0x07, sub=1 → result=0xFE, cout=0 (borrow), overflow=0.
   - a=0x07, b=0x05, sub=1 → result=0x02, cout=1.
4. **Wrap-around:** WIDTH=8, a=0xFF, b=0x01, sub=0 → result=0x00, cout=1, overflow=0.
   - a=0x80, b=0x01, sub=1 → result=0x7F, overflow=1.
5. **Handshake:**
   - Toggle start and change a/b during RUN → first result unchanged.
   - Hold start high through DONE with new operands (0x10+0x20) → second done 9 cycles after the first; result=0x30.
6. **Reset mid-RUN:** assert rst at count=4 → IDLE, no done pulse.
   - After release, a=0x3C, b=0x0F, sub=1 → result=0x2D, cout=1.
   - Run a randomized sweep against a reference model of a±b.

Source files
------------

// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - bit-serial two's-complement adder/subtractor
// One full-adder slice with a registered carry, LSB first, start/done handshake.
module serial_addsub #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [WIDTH-1:0] op_a, op_b;
  logic [CW-1:0]   count;
  logic            carry;
  logic            accept;
  logic            s, c_next;

  // start is only honoured outside RUN; operands are never re-sampled mid-operation
  assign accept = (state != RUN) && start;
  assign s      = op_a[0] ^ op_b[0] ^ carry;
  assign c_next = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (count == LAST) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a     <= '0;
      op_b     <= '0;
      carry    <= 1'b0;
      count    <= '0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      // subtraction is A + ~B + 1: invert B and seed the carry with 1
      op_a     <= a;
      op_b     <= sub ? ~b : b;
      carry    <= sub;
      count    <= '0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (state == RUN) begin
      op_a   <= op_a >> 1;
      op_b   <= op_b >> 1;
      result <= {s, result[WIDTH-1:1]};
      carry  <= c_next;
      count  <= count + 1'b1;
      if (count == LAST) begin
        // carry here is the carry into the MSB; c_next is the carry out of it
        cout     <= c_next;
        overflow <= carry ^ c_next;
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// tb/tb_serial_addsub.sv - directed and random checks for serial_addsub
// Runs at WIDTH=8 against hand-computed vectors and an a+-b reference.
module tb_serial_addsub;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;

  int total = 0;
  int bad   = 0;

  serial_addsub #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Issue one operation; lat counts edges from (and including) the accepting edge to done.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts,
                       output int lat, output int nbusy, output int both);
    @(negedge clk);
    a = ta; b = tb_v; sub = ts; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1; nbusy = 0; both = 0;
    if (busy) nbusy++;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (busy) nbusy++;
      if (busy && done) both++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    #3;
    total++;
    if ({busy, done, result, cout, overflow} !== '0) begin
      bad++;
      $display("FAIL reset_init busy=%b done=%b result=%h cout=%b ovf=%b want all 0",
               busy, done, result, cout, overflow);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_add_overflow;
    int lat, nbusy, both;
    do_op(8'h7F, 8'h01, 1'b0, lat, nbusy, both);
    total++;
    if (lat !== 9) begin bad++; $display("FAIL add_latency got=%0d want=9", lat); end
    total++;
    if (nbusy !== 8) begin bad++; $display("FAIL add_busy_cycles got=%0d want=8", nbusy); end
    total++;
    if (both !== 0) begin bad++; $display("FAIL busy_done_overlap got=%0d want=0", both); end
    total++;
    if ({result, cout, overflow} !== {8'h80, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL add_7f_01 got=%h/%b/%b want=80/0/1", result, cout, overflow);
    end
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0 || result !== 8'h80) begin
      bad++;
      $display("FAIL done_pulse_hold done=%b result=%h want 0/80", done, result);
    end
  endtask

  task automatic test_async_reset;
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    total++;
    if ({busy, done, result, cout, overflow} !== '0) begin
      bad++;
      $display("FAIL async_reset busy=%b done=%b result=%h cout=%b ovf=%b want all 0",
               busy, done, result, cout, overflow);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_sub_borrow;
    int lat, nbusy, both;
    do_op(8'h05, 8'h07, 1'b1, lat, nbusy, both);
    total++;
    if ({result, cout, overflow} !== {8'hFE, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL sub_05_07 got=%h/%b/%b want=fe/0/0", result, cout, overflow);
    end
    do_op(8'h07, 8'h05, 1'b1, lat, nbusy, both);
    total++;
    if ({result, cout, overflow} !== {8'h02, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL sub_07_05 got=%h/%b/%b want=02/1/0", result, cout, overflow);
    end
  endtask

  task automatic test_wrap;
    int lat, nbusy, both;
    do_op(8'hFF, 8'h01, 1'b0, lat, nbusy, both);
    total++;
    if ({result, cout, overflow} !== {8'h00, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL add_ff_01 got=%h/%b/%b want=00/1/0", result, cout, overflow);
    end
    do_op(8'h80, 8'h01, 1'b1, lat, nbusy, both);
    total++;
    if ({result, cout, overflow} !== {8'h7F, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL sub_80_01 got=%h/%b/%b want=7f/1/1", result, cout, overflow);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    @(negedge clk);
    a = 8'h12; b = 8'h34; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      start = ~start; a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
    end
    @(negedge clk);
    a = 8'h10; b = 8'h20; sub = 1'b0; start = 1'b1;
    n = 0;
    while (!done && n < 40) begin @(posedge clk); #1; n++; end
    total++;
    if (done !== 1'b1 || result !== 8'h46) begin
      bad++;
      $display("FAIL handshake_first done=%b result=%h want 1/46", done, result);
    end
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!done && n < 40);
    start = 1'b0;
    total++;
    if (n !== 9) begin bad++; $display("FAIL b2b_spacing got=%0d want=9", n); end
    total++;
    if ({result, cout, overflow} !== {8'h30, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL b2b_result got=%h/%b/%b want=30/0/0", result, cout, overflow);
    end
  endtask

  task automatic test_reset_mid_run;
    int seen, lat, nbusy, both;
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({busy, done, result} !== '0) begin
      bad++;
      $display("FAIL mid_run_reset busy=%b done=%b result=%h want 0/0/00", busy, done, result);
    end
    @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (15) begin @(posedge clk); #1; if (done || busy) seen++; end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL no_done_after_reset got=%0d want=0", seen); end
    do_op(8'h3C, 8'h0F, 1'b1, lat, nbusy, both);
    total++;
    if ({result, cout, overflow} !== {8'h2D, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL sub_3c_0f got=%h/%b/%b want=2d/1/0", result, cout, overflow);
    end
  endtask

  task automatic test_random;
    int lat, nbusy, both;
    logic [W-1:0] ra, rb, er;
    logic         rs, ec, eo;
    logic [W:0]   full;
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
      if (rs) full = {1'b0, ra} - {1'b0, rb};
      else    full = {1'b0, ra} + {1'b0, rb};
      er = full[W-1:0];
      ec = rs ? (ra >= rb) : full[W];
      eo = rs ? ((ra[W-1] != rb[W-1]) && (er[W-1] != ra[W-1]))
              : ((ra[W-1] == rb[W-1]) && (er[W-1] != ra[W-1]));
      do_op(ra, rb, rs, lat, nbusy, both);
      total++;
      if ({result, cout, overflow} !== {er, ec, eo} || lat !== 9) begin
        bad++;
        $display("FAIL random a=%h b=%h sub=%b got=%h/%b/%b lat=%0d want=%h/%b/%b lat=9",
                 ra, rb, rs, result, cout, overflow, lat, er, ec, eo);
      end
    end
  endtask

  initial begin
    test_reset;
    test_add_overflow;
    test_async_reset;
    test_sub_borrow;
    test_wrap;
    test_back_to_back;
    test_reset_mid_run;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
